// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, parity modes and frame-length helper for uart_tx_frame
package uart_pkg;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_PARITY  = 3'd3,
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } state_t;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;
   function automatic int frame_len(input int d, input int data_bits, input int parity, input int stop_bits);
      return d * (1 + data_bits + (parity != PARITY_NONE ? 1 : 0) + stop_bits);
   endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: valid/ready byte handshake plus serial line status of the transmitter
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8,
   parameter int CNT_W     = 16
);
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] tx_byte;
   logic [CNT_W-1:0]     clks_per_bit;
   logic                 tx_serial;
   logic                 tx_busy;
   logic                 tx_done;
   modport master (output tx_valid, tx_byte, clks_per_bit, input tx_ready, tx_serial, tx_busy, tx_done);
   modport slave  (input tx_valid, tx_byte, clks_per_bit, output tx_ready, tx_serial, tx_busy, tx_done);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable divisor counter, strobes bit_end on the last clock of each bit period
module uart_baud_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             i_sys_clk,
   input  logic             i_rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   output logic             bit_end
);
   logic [CNT_W-1:0] cnt, div;
   assign bit_end = cnt == div - CNT_W'(1);
   always_ff @(posedge i_sys_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         cnt <= '0;
         div <= '0;
      end else if (load) begin
         cnt <= '0;
         div <= div_in;
      end else if (en)
         cnt <= bit_end ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input and zero-gap back-to-back frames
module uart_tx_frame import uart_pkg::*; #(
   parameter int DATA_BITS        = 8,
   parameter int PARITY           = 0,
   parameter int STOP_BITS        = 1,
   parameter int CNT_W            = 16,
   parameter int DEF_CLKS_PER_BIT = 434
) (
   input logic            i_sys_clk,
   input logic            i_rst_n,
   uart_tx_frame_if.slave tx
);
   localparam int IW = $clog2(DATA_BITS);
   state_t               state, nstate;
   logic [DATA_BITS-1:0] shift, shift_d;
   logic [IW-1:0]        idx;
   logic [CNT_W-1:0]     div_sel;
   logic                 stop_idx, par, par_d, bit_end, accept, last_data, last_stop, serial_d;
   assign div_sel   = tx.clks_per_bit >= CNT_W'(2) ? tx.clks_per_bit : CNT_W'(DEF_CLKS_PER_BIT);
   assign par_d     = PARITY == PARITY_ODD ? ~^tx.tx_byte : ^tx.tx_byte;
   assign last_data = state == S_DATA && bit_end && idx == IW'(DATA_BITS - 1);
   assign last_stop = state == S_STOP && bit_end && stop_idx == 1'(STOP_BITS - 1);
   assign accept    = tx.tx_valid && tx.tx_ready;

   uart_baud_cnt #(.CNT_W(CNT_W)) u_baud (
      .i_sys_clk (i_sys_clk),
      .i_rst_n   (i_rst_n),
      .load      (accept),
      .en        (state != S_IDLE && state != S_CLEANUP),
      .div_in    (div_sel),
      .bit_end   (bit_end)
   );

   always_ff @(posedge i_sys_clk or negedge i_rst_n)
      if (!i_rst_n) state <= S_IDLE;
      else          state <= nstate;

   always_comb begin
      nstate = state;
      case (state)
         S_IDLE:    nstate = tx.tx_valid ? S_START : S_IDLE;
         S_START:   if (bit_end) nstate = S_DATA;
         S_DATA:    if (last_data) nstate = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
         S_PARITY:  if (bit_end) nstate = S_STOP;
         S_STOP:    if (last_stop) nstate = tx.tx_valid ? S_START : S_CLEANUP;
         S_CLEANUP: nstate = S_IDLE;
         default:   nstate = S_IDLE;
      endcase
   end

   // serial is registered, so it is driven from the state being entered, not the current one
   always_comb begin
      tx.tx_ready = state == S_IDLE || last_stop;
      shift_d     = accept ? tx.tx_byte : (state == S_DATA && bit_end) ? shift >> 1 : shift;
      serial_d    = nstate == S_START ? 1'b0 : nstate == S_DATA ? shift_d[0] : nstate == S_PARITY ? par : 1'b1;
   end

   always_ff @(posedge i_sys_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         shift        <= '0;
         idx          <= '0;
         stop_idx     <= 1'b0;
         par          <= 1'b0;
         tx.tx_serial <= 1'b1;
         tx.tx_busy   <= 1'b0;
         tx.tx_done   <= 1'b0;
      end else begin
         shift        <= shift_d;
         idx          <= accept || last_data ? '0 : (state == S_DATA && bit_end) ? idx + IW'(1) : idx;
         stop_idx     <= accept || last_stop ? 1'b0 : (state == S_STOP && bit_end) ? ~stop_idx : stop_idx;
         par          <= accept ? par_d : par;
         tx.tx_serial <= serial_d;
         tx.tx_busy   <= nstate inside {S_START, S_DATA, S_PARITY, S_STOP};
         tx.tx_done   <= last_stop;
      end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table, random and corner-case checks of uart_tx_frame against a bit-period line model
module tb_uart_tx_frame;
   import uart_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;

   uart_tx_frame_if #(.DATA_BITS(8), .CNT_W(16)) ifa ();
   uart_tx_frame_if #(.DATA_BITS(7), .CNT_W(16)) ifb ();

   uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CNT_W(16), .DEF_CLKS_PER_BIT(5)) dut_a (
      .i_sys_clk (clk),
      .i_rst_n   (rst_n),
      .tx        (ifa)
   );
   uart_tx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CNT_W(16), .DEF_CLKS_PER_BIT(5)) dut_b (
      .i_sys_clk (clk),
      .i_rst_n   (rst_n),
      .tx        (ifb)
   );

   typedef struct {
      int          w;
      logic [7:0]  b;
      logic [15:0] cpb;
      logic [15:0] cpb_after;
      int          d;
      logic        par;
   } vec_t;
   vec_t tbl[8];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // line level k cycles after accept: start, data LSB first, parity, then stop/idle high
   function automatic logic exp_line(int k, int d, logic [7:0] b, int nd, logic par);
      int i = (k - 1) / d;
      if (i == 0) return 1'b0;
      if (i <= nd) return b[i-1];
      if (i == nd + 1) return par;
      return 1'b1;
   endfunction

   function automatic logic ser(int w); return w != 0 ? ifb.tx_serial : ifa.tx_serial; endfunction
   function automatic logic bsy(int w); return w != 0 ? ifb.tx_busy : ifa.tx_busy; endfunction
   function automatic logic dn(int w);  return w != 0 ? ifb.tx_done : ifa.tx_done; endfunction
   function automatic logic rdy(int w); return w != 0 ? ifb.tx_ready : ifa.tx_ready; endfunction

   task automatic drive(int w, logic v, logic [7:0] b, logic [15:0] c);
      if (w != 0) begin
         ifb.tx_valid = v; ifb.tx_byte = b[6:0]; ifb.clks_per_bit = c;
      end else begin
         ifa.tx_valid = v; ifa.tx_byte = b; ifa.clks_per_bit = c;
      end
   endtask

   task automatic wait_ready(int w);
      int t = 0;
      while (!rdy(w) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", rdy(w), 1);
   endtask

   task automatic send_frame(int w, logic [7:0] b, logic [15:0] cpb, logic [15:0] cpb_after, int d, logic par);
      int nd = w != 0 ? 7 : 8;
      int f  = frame_len(d, nd, w != 0 ? PARITY_ODD : PARITY_EVEN, w != 0 ? 2 : 1);
      wait_ready(w);
      drive(w, 1'b1, b, cpb);
      @(negedge clk);
      drive(w, 1'b0, ~b, cpb_after);
      for (int k = 1; k <= f; k++) begin
         chk("serial", ser(w), exp_line(k, d, b, nd, par));
         chk("busy", bsy(w), 1);
         chk("done_low", dn(w), 0);
         @(negedge clk);
      end
      chk("done_pulse", dn(w), 1);
      chk("busy_end", bsy(w), 0);
      chk("serial_cleanup", ser(w), 1);
      chk("ready_cleanup", rdy(w), 0);
      @(negedge clk);
      chk("done_once", dn(w), 0);
      chk("ready_idle", rdy(w), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f;
      tbl[0] = '{0, 8'hA5, 16'd4, 16'd4, 4, 1'b0};
      tbl[1] = '{0, 8'h01, 16'd0, 16'd0, 5, 1'b1};
      tbl[2] = '{0, 8'h7F, 16'd4, 16'd8, 4, 1'b1};
      tbl[3] = '{0, 8'h00, 16'd1, 16'd1, 5, 1'b0};
      tbl[4] = '{0, 8'hFF, 16'd2, 16'd2, 2, 1'b0};
      tbl[5] = '{1, 8'h00, 16'd3, 16'd3, 3, 1'b1};
      tbl[6] = '{1, 8'h55, 16'd0, 16'd9, 5, 1'b1};
      tbl[7] = '{1, 8'h7F, 16'd2, 16'd2, 2, 1'b0};
      drive(0, 1'b0, 8'h00, 16'd4);
      drive(1, 1'b0, 8'h00, 16'd4);
      repeat (3) @(negedge clk);
      chk("reset_serial", ser(0), 1);
      chk("reset_busy", bsy(0), 0);
      chk("reset_done", dn(0), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", rdy(0), 1);
      chk("reset_ready_b", rdy(1), 1);

      for (int i = 0; i < 8; i++)
         send_frame(tbl[i].w, tbl[i].b, tbl[i].cpb, tbl[i].cpb_after, tbl[i].d, tbl[i].par);

      for (int i = 0; i < 20; i++) begin
         logic [7:0]  b   = 8'($urandom);
         logic [15:0] cpb = 16'($urandom_range(0, 6));
         send_frame(0, b, cpb, 16'($urandom), cpb >= 2 ? int'(cpb) : 5, 1'($countones(b) % 2));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // back-to-back: valid held across both frames, second accepted in the last stop clock
      f = frame_len(4, 8, PARITY_EVEN, 1);
      wait_ready(0);
      drive(0, 1'b1, 8'h01, 16'd4);
      @(negedge clk);
      drive(0, 1'b1, 8'h80, 16'd4);
      for (int k = 1; k <= 2 * f + 1; k++) begin
         if (k == f + 1) drive(0, 1'b0, 8'h00, 16'd4);
         chk("b2b_serial", ser(0), k <= f ? exp_line(k, 4, 8'h01, 8, 1'b1) :
                                   k <= 2 * f ? exp_line(k - f, 4, 8'h80, 8, 1'b1) : 1'b1);
         chk("b2b_busy", bsy(0), k <= 2 * f);
         chk("b2b_done", dn(0), k == f + 1 || k == 2 * f + 1);
         if (k == f) chk("b2b_ready_last_stop", rdy(0), 1);
         @(negedge clk);
      end

      // asynchronous reset during data bit 3
      wait_ready(0);
      drive(0, 1'b1, 8'h00, 16'd4);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 16'd4);
      repeat (17) @(negedge clk);
      chk("pre_reset_serial", ser(0), 0);
      chk("pre_reset_busy", bsy(0), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_serial", ser(0), 1);
      chk("async_rst_busy", bsy(0), 0);
      chk("async_rst_done", dn(0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_ready", rdy(0), 1);
         chk("post_rst_serial", ser(0), 1);
         chk("post_rst_done", dn(0), 0);
         @(negedge clk);
      end
      send_frame(0, 8'hA5, 16'd4, 16'd4, 4, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
